// File: rtl/operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | operand_fetch: issue stage with a pending-write scoreboard in front of a |
// | 2R/1W register file. Optional `OPFETCH_BYPASS_EN forwards writebacks.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module operand_fetch #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_FILE_SIZE = 32,
  localparam int ADDR_WIDTH   = $clog2(REG_FILE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_rd_wen,
  output logic [ADDR_WIDTH-1:0] o_raddr1,
  output logic [ADDR_WIDTH-1:0] o_raddr2,
  input  logic [DATA_WIDTH-1:0] i_rdata1,
  input  logic [DATA_WIDTH-1:0] i_rdata2,
  input  logic                  i_wb_wen,
  input  logic [ADDR_WIDTH-1:0] i_wb_waddr,
  input  logic [DATA_WIDTH-1:0] i_wb_wdata,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_op1,
  output logic [DATA_WIDTH-1:0] o_op2,
  output logic [ADDR_WIDTH-1:0] o_rd,
  output logic                  o_rd_wen
);

  logic [REG_FILE_SIZE-1:0] pend_q, pend_d;
  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    op1_q, op1_d;
  logic [DATA_WIDTH-1:0]    op2_q, op2_d;
  logic [ADDR_WIDTH-1:0]    rd_q, rd_d;
  logic                     rd_wen_q, rd_wen_d;

  logic wb_hit1, wb_hit2, wb_hit_rd;
  logic src_haz1, src_haz2, waw_haz;
  logic accept;
  logic [DATA_WIDTH-1:0] op1_sel, op2_sel;

  assign o_raddr1 = i_rs1;
  assign o_raddr2 = i_rs2;

  assign wb_hit1   = i_wb_wen && (i_wb_waddr == i_rs1);
  assign wb_hit2   = i_wb_wen && (i_wb_waddr == i_rs2);
  assign wb_hit_rd = i_wb_wen && (i_wb_waddr == i_rd);

`ifdef OPFETCH_BYPASS_EN
  assign src_haz1 = (i_rs1 != '0) && pend_q[i_rs1] && !wb_hit1;
  assign src_haz2 = (i_rs2 != '0) && pend_q[i_rs2] && !wb_hit2;

  always_comb begin
    op1_sel = i_rdata1;
    op2_sel = i_rdata2;
    if (i_rs1 == '0)  op1_sel = '0;
    else if (wb_hit1) op1_sel = i_wb_wdata;
    if (i_rs2 == '0)  op2_sel = '0;
    else if (wb_hit2) op2_sel = i_wb_wdata;
  end
`else
  // A same-cycle writeback is invisible to the register file read, so wait a cycle.
  assign src_haz1 = (i_rs1 != '0) && (pend_q[i_rs1] || wb_hit1);
  assign src_haz2 = (i_rs2 != '0) && (pend_q[i_rs2] || wb_hit2);

  always_comb begin
    op1_sel = i_rdata1;
    op2_sel = i_rdata2;
    if (i_rs1 == '0) op1_sel = '0;
    if (i_rs2 == '0) op2_sel = '0;
  end

  logic unused_wb_wdata;
  assign unused_wb_wdata = ^i_wb_wdata;
`endif

  assign waw_haz = i_rd_wen && (i_rd != '0) && pend_q[i_rd] && !wb_hit_rd;

  assign o_ready = rst_n && !i_flush && (!valid_q || i_ready)
                 && !src_haz1 && !src_haz2 && !waw_haz;
  assign accept  = i_valid && o_ready;

  // Order matters: writeback clear, then flush clear, then issue set.
  always_comb begin
    pend_d = pend_q;
    if (i_wb_wen)
      pend_d[i_wb_waddr] = 1'b0;
    if (i_flush && valid_q && rd_wen_q)
      pend_d[rd_q] = 1'b0;
    if (accept && i_rd_wen)
      pend_d[i_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    valid_d  = valid_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      op1_d    = op1_sel;
      op2_d    = op2_sel;
      rd_d     = i_rd;
      rd_wen_d = i_rd_wen;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= '0;
      valid_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rd_q     <= rd_d;
      rd_wen_q <= rd_wen_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_op1    = op1_q;
  assign o_op2    = op2_q;
  assign o_rd     = rd_q;
  assign o_rd_wen = rd_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// Bench for operand_fetch: directed scenarios plus randomized traffic against
// a behavioural scoreboard model and a model register file.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int RF = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, o_ready;
  logic [AW-1:0] i_rs1, i_rs2, i_rd;
  logic          i_rd_wen;
  logic [AW-1:0] o_raddr1, o_raddr2;
  logic [DW-1:0] i_rdata1, i_rdata2;
  logic          i_wb_wen;
  logic [AW-1:0] i_wb_waddr;
  logic [DW-1:0] i_wb_wdata;
  logic          i_flush, o_valid, i_ready;
  logic [DW-1:0] o_op1, o_op2;
  logic [AW-1:0] o_rd;
  logic          o_rd_wen;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_WIDTH(DW), .REG_FILE_SIZE(RF)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rd_wen(i_rd_wen),
    .o_raddr1(o_raddr1), .o_raddr2(o_raddr2),
    .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
    .i_wb_wen(i_wb_wen), .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_op1(o_op1), .o_op2(o_op2), .o_rd(o_rd), .o_rd_wen(o_rd_wen)
  );

  // Register file model: r0 returns junk so the stage must force zero itself.
  logic [DW-1:0] regs [RF];
  logic [DW-1:0] r0_junk;
  assign i_rdata1 = (i_rs1 == '0) ? r0_junk : regs[i_rs1];
  assign i_rdata2 = (i_rs2 == '0) ? r0_junk : regs[i_rs2];

  bit            m_known = 1'b0;
  bit            m_pend [RF];
  bit            m_valid, m_rd_wen;
  logic [DW-1:0] m_op1, m_op2;
  logic [AW-1:0] m_rd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wb_hits(input logic [AW-1:0] r);
    return i_wb_wen && (i_wb_waddr == r);
  endfunction

  function automatic bit src_blocked(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
`ifdef OPFETCH_BYPASS_EN
    return m_pend[r] && !wb_hits(r);
`else
    return m_pend[r] || wb_hits(r);
`endif
  endfunction

  function automatic bit model_ready();
    if (!rst_n || i_flush) return 1'b0;
    if (m_valid && !i_ready) return 1'b0;
    if (src_blocked(i_rs1) || src_blocked(i_rs2)) return 1'b0;
    if (i_rd_wen && i_rd != '0 && m_pend[i_rd] && !wb_hits(i_rd)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] r);
    if (r == '0) return '0;
`ifdef OPFETCH_BYPASS_EN
    if (wb_hits(r)) return i_wb_wdata;
`endif
    return regs[r];
  endfunction

  // One clock: compare at negedge, advance model, apply after posedge.
  task automatic tick();
    bit            rdy, acc;
    bit            n_pend [RF];
    bit            n_valid, n_rd_wen;
    logic [DW-1:0] n_op1, n_op2;
    logic [AW-1:0] n_rd;
    @(negedge clk);
    rdy = model_ready();
    if (m_known) begin
      chk("ready", o_ready, rdy);
      chk("raddr1", o_raddr1, i_rs1);
      chk("raddr2", o_raddr2, i_rs2);
      chk("valid", o_valid, m_valid);
      if (m_valid) begin
        chk("op1", o_op1, m_op1);
        chk("op2", o_op2, m_op2);
        chk("rd", o_rd, m_rd);
        chk("rd_wen", o_rd_wen, m_rd_wen);
      end
    end
    acc = i_valid && rdy;
    n_pend = m_pend; n_valid = m_valid; n_rd_wen = m_rd_wen;
    n_op1 = m_op1; n_op2 = m_op2; n_rd = m_rd;
    if (!rst_n) begin
      foreach (n_pend[i]) n_pend[i] = 1'b0;
      n_valid = 0; n_rd_wen = 0; n_op1 = '0; n_op2 = '0; n_rd = '0;
    end else begin
      if (i_wb_wen) n_pend[i_wb_waddr] = 1'b0;
      if (i_flush && m_valid && m_rd_wen) n_pend[m_rd] = 1'b0;
      if (acc && i_rd_wen) n_pend[i_rd] = 1'b1;
      n_pend[0] = 1'b0;
      if (i_flush) n_valid = 0;
      else if (acc) begin
        n_valid = 1; n_op1 = model_operand(i_rs1); n_op2 = model_operand(i_rs2);
        n_rd = i_rd; n_rd_wen = i_rd_wen;
      end else if (m_valid && i_ready) n_valid = 0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) m_known = 1'b1;
    m_pend = n_pend; m_valid = n_valid; m_rd_wen = n_rd_wen;
    m_op1 = n_op1; m_op2 = n_op2; m_rd = n_rd;
    if (i_wb_wen && i_wb_waddr != '0) regs[i_wb_waddr] = i_wb_wdata;
  endtask

  task automatic idle();
    i_valid = 0; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_rd_wen = 0;
    i_wb_wen = 0; i_wb_waddr = '0; i_wb_wdata = '0; i_flush = 0; i_ready = 1;
  endtask

  function automatic logic [AW-1:0] rnd_reg();
    if ($urandom_range(3, 0) == 0) return AW'($urandom_range(RF - 1, 0));
    return AW'($urandom_range(7, 0));
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (regs[i]) regs[i] = $urandom;
    regs[0] = '0; regs[1] = 32'h1111; regs[2] = 32'h2222;
    regs[3] = 32'h11; regs[4] = 32'h22;
    r0_junk = 32'hFFFF_FFFF;

    // Reset
    idle(); rst_n = 0;
    tick(); tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_op1", o_op1, 0);
    chk("rst_op2", o_op2, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_rd_wen", o_rd_wen, 0);
    chk("rst_ready", o_ready, 0);
    rst_n = 1;

    // Basic accept
    i_valid = 1; i_rs1 = 3; i_rs2 = 4; i_rd = 5; i_rd_wen = 1;
    tick();
    chk("t1_valid", o_valid, 1);
    chk("t1_op1", o_op1, 32'h11);
    chk("t1_op2", o_op2, 32'h22);
    chk("t1_rd", o_rd, 5);
    chk("t1_model_pend5", m_pend[5], 1);
    chk("t1_model_op1", m_op1, 32'h11);

    // RAW on r5
    i_rs1 = 5; i_rs2 = 0; i_rd = 6; #1;
    chk("raw_stall0", o_ready, 0);
    tick();
    chk("raw_stall1", o_ready, 0);
    tick();
    i_wb_wen = 1; i_wb_waddr = 5; i_wb_wdata = 32'hABCD; #1;
`ifdef OPFETCH_BYPASS_EN
    chk("raw_bypass_ready", o_ready, 1);
    tick();
    i_wb_wen = 0;
`else
    chk("raw_wb_cycle_ready", o_ready, 0);
    tick();
    i_wb_wen = 0; #1;
    chk("raw_next_ready", o_ready, 1);
    tick();
`endif
    chk("raw_op1", o_op1, 32'hABCD);
    chk("raw_rd", o_rd, 6);

    // Backpressure
    i_ready = 0; i_rs1 = 1; i_rs2 = 2; i_rd = 0; i_rd_wen = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", o_ready, 0);
      tick();
      chk("bp_valid", o_valid, 1);
      chk("bp_op1", o_op1, 32'hABCD);
      chk("bp_rd", o_rd, 6);
    end
    i_ready = 1; #1;
    chk("bp_release_ready", o_ready, 1);
    tick();
    chk("bp_new_op1", o_op1, 32'h1111);
    chk("bp_new_op2", o_op2, 32'h2222);

    // Register zero
    i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_rd_wen = 1;
    tick();
    chk("r0_op1", o_op1, 0);
    chk("r0_op2", o_op2, 0);
    #1;
    chk("r0_follow_ready", o_ready, 1);
    tick();

    // Flush
    i_rs1 = 1; i_rs2 = 2; i_rd = 7; i_rd_wen = 1;
    tick();
    chk("fl_rd", o_rd, 7);
    i_valid = 0; i_flush = 1; #1;
    chk("fl_ready", o_ready, 0);
    tick();
    chk("fl_valid", o_valid, 0);
    i_flush = 0; i_valid = 1; i_rs1 = 7; i_rs2 = 0; i_rd = 0; i_rd_wen = 0; #1;
    chk("fl_rs7_ready", o_ready, 1);
    tick();

    // Reset mid-operation
    i_rs1 = 0; i_rs2 = 0; i_rd = 3; i_rd_wen = 1;
    tick();
    i_rd = 9;
    tick();
    i_valid = 0; i_ready = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mr_valid", o_valid, 0);
    i_valid = 1; i_ready = 1; i_rs1 = 9; i_rs2 = 3; i_rd = 6; i_rd_wen = 1; #1;
    chk("mr_ready", o_ready, 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(99, 0) != 0);
      i_valid    = ($urandom_range(3, 0) != 0);
      i_rs1      = rnd_reg();
      i_rs2      = rnd_reg();
      i_rd       = rnd_reg();
      i_rd_wen   = ($urandom_range(2, 0) != 0);
      i_wb_wen   = ($urandom_range(1, 0) != 0);
      i_wb_waddr = rnd_reg();
      i_wb_wdata = $urandom;
      i_flush    = ($urandom_range(15, 0) == 0);
      i_ready    = ($urandom_range(3, 0) != 0);
      tick();
    end
    idle(); rst_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the 2-read/1-write register file.
- Accepts decoded instructions, drives the register file read addresses, and captures the read data into an output pipeline register for execute.
- A per-register pending scoreboard detects RAW/WAW hazards against in-flight writers; the stage stalls until the hazard clears.
- Writeback traffic also feeds the register file write port. When enabled, write data bypasses the register file, because a same-cycle read there returns stale data.

Parameters:
DATA_WIDTH, 32, operand/writeback data width
REG_FILE_SIZE, 32, number of architectural registers; register 0 is hardwired zero
(localparam ADDR_WIDTH = $clog2(REG_FILE_SIZE))

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage accepts upstream instruction this cycle
i_rs1  input  ADDR_WIDTH  source register 1
i_rs2  input  ADDR_WIDTH  source register 2
i_rd  input  ADDR_WIDTH  destination register
i_rd_wen  input  1  instruction writes i_rd
o_raddr1  output  ADDR_WIDTH  register file read address 1
o_raddr2  output  ADDR_WIDTH  register file read address 2
i_rdata1  input  DATA_WIDTH  register file read data 1 (combinational read)
i_rdata2  input  DATA_WIDTH  register file read data 2
i_wb_wen  input  1  writeback valid (same signal drives register file write enable)
i_wb_waddr  input  ADDR_WIDTH  writeback register
i_wb_wdata  input  DATA_WIDTH  writeback data
i_flush  input  1  kill instruction held in output register
o_valid  output  1  operands valid to execute
i_ready  input  1  execute accepts
o_op1  output  DATA_WIDTH  operand 1
o_op2  output  DATA_WIDTH  operand 2
o_rd  output  ADDR_WIDTH  destination register
o_rd_wen  output  1  destination write enable

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset (rst_n=0 at posedge):
  - o_valid=0; o_op1, o_op2, o_rd, o_rd_wen = 0.
  - All pending bits = 0.
  - o_ready is driven 0 while rst_n=0.
- Read addresses:
  - o_raddr1=i_rs1 and o_raddr2=i_rs2, combinationally, every cycle.
- Pending bit pend[r]:
  - Set when an instruction with i_rd_wen=1 and i_rd!=0 is accepted.
  - Cleared when i_wb_wen=1 and i_wb_waddr=r.
  - If set and clear hit the same register in the same cycle, set wins.
  - pend[0] is always 0.
- Hazard terms:
  - src_haz(rs) = rs!=0 && pend[rs] && !(i_wb_wen && i_wb_waddr==rs).
  - waw_haz = i_rd_wen && i_rd!=0 && pend[i_rd] && !(i_wb_wen && i_wb_waddr==i_rd).
- Stall:
  - o_ready = rst_n && !i_flush && (!o_valid || i_ready) && !src_haz(i_rs1) && !src_haz(i_rs2) && !waw_haz.
  - o_ready may depend combinationally on i_rs1/i_rs2/i_rd.
- Accept (i_valid && o_ready), latency 1 cycle:
  - Next cycle o_valid=1.
  - o_op1/o_op2 = selected operand values; o_rd/o_rd_wen captured.
- Output register otherwise:
  - If o_valid && i_ready and no accept, o_valid goes to 0.
  - If o_valid && !i_ready, all outputs hold stable.
- Operand select, per source: rs==0 gives 0; else bypass match gives i_wb_wdata; else i_rdata.
- Flush (i_flush=1):
  - Next cycle o_valid=0.
  - If o_valid && o_rd_wen && o_rd!=0, pend[o_rd] is cleared (this wins over a same-cycle writeback).
  - Execute must not count a handshake in the flush cycle.
  - No accept occurs in the flush cycle.
- Writeback to register 0 is ignored by the scoreboard.
- A writeback to a non-pending register updates nothing here; operands still bypass if enabled.

Optional Feature:
- Macro `OPFETCH_BYPASS_EN`.
- Defined:
  - A source matching the current writeback (i_wb_wen && i_wb_waddr==rs && rs!=0) takes i_wb_wdata.
  - The hazard clears in the writeback cycle.
- Undefined:
  - No bypass mux; src_haz drops the writeback-match exception, i.e. src_haz(rs) = rs!=0 && (pend[rs] || (i_wb_wen && i_wb_waddr==rs)).
  - The stage stalls exactly one extra cycle and reads the updated register file next cycle.
  - waw_haz still uses the writeback exception.

Test Plan:
- Reset, then accept rs1=3, rs2=4 with rdata1=0x11, rdata2=0x22, rd=5, i_ready=1:
  - Next cycle o_valid=1, o_op1=0x11, o_op2=0x22, o_rd=5; pend[5]=1.
- RAW: issue rd=5, then rs1=5 while pend[5]=1 and no writeback:
  - o_ready=0 until i_wb_wen=1, waddr=5, wdata=0xABCD.
  - With bypass: accepted that cycle, o_op1=0xABCD.
  - Without bypass: accepted one cycle later.
- Backpressure: o_valid=1, i_ready=0 for 3 cycles:
  - o_op1/o_op2/o_rd stable.
  - o_ready=0.
  - Upstream instruction held until i_ready=1.
- Register 0: rs1=0, rs2=0 with rdata=0xFFFF_FFFF, rd=0, rd_wen=1:
  - o_op1=o_op2=0; no pending bit set.
  - Follow-up reading r0 does not stall.
- Flush: output holds rd=7 (pend[7]=1), assert i_flush with i_ready=1:
  - Next cycle o_valid=0, pend[7]=0; subsequent rs1=7 accepted immediately.
- Reset mid-operation: pend[3,9]=1, o_valid=1, drive rst_n=0 one cycle:
  - o_valid=0, all pending cleared.
  - rs1=9 accepted in the first cycle after reset release.
